// File: rtl/daq_pkg.sv
// Shared constants and types for the synthetic sensor front-end.
// Imported by the LFSR and the acquisition top.
package daq_pkg;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int          AVG_TAPS  = 4;
  localparam int          AVG_SHIFT = 2;

  typedef logic [15:0] sample_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  // Clamp an 18-bit signed value into the unsigned 16-bit range.
  function automatic sample_t sat16(input logic signed [17:0] v);
    sample_t r;
    unique case (1'b1)
      v[17]:   r = '0;
      v[16]:   r = 16'hFFFF;
      default: r = v[15:0];
    endcase
    return r;
  endfunction
endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois right-shift LFSR with loadable seed.
// Advances one step per enabled cycle.
module lfsr16
  import daq_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  sample_t seed,
  input  logic    en,
  output sample_t state
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= seed;
    end else if (en) begin
      state <= (state >> 1) ^ (state[0] ? LFSR_MASK : 16'h0000);
    end
  end

endmodule

// File: rtl/data_acquisition.sv
// Synthetic sensor: baseline + triangle drift + LFSR noise,
// saturated and smoothed by a 4-tap moving average.
module data_acquisition
  import daq_pkg::*;
#(
  parameter int          SAMPLE_DIV = 4,
  parameter logic [15:0] BASELINE   = 16'h4000,
  parameter logic [15:0] TRI_STEP   = 16'd64,
  parameter logic [15:0] TRI_PEAK   = 16'h1000,
  parameter int          NOISE_BITS = 6,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic    clk,
  input  logic    reset,
  output sample_t sensor_data
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SAMPLE_DIV - 1);
  localparam logic signed [17:0] NOISE_OFS = 18'(1 << (NOISE_BITS - 1));

  logic [DW-1:0] div_cnt;
  logic          tick;

  sample_t lfsr;
  sample_t tri_q, tri_d;
  dir_e    dir_q, dir_d;
  logic [16:0] tri_up;

  logic signed [17:0] noise;
  logic signed [17:0] raw_wide;
  sample_t            raw;

  sample_t     hist [AVG_TAPS];
  logic [17:0] sum_q;
  logic [17:0] sum_new;

  assign tick = (div_cnt == DIV_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .en    (tick),
    .state (lfsr)
  );

  // Noise is centred on zero: low LFSR bits minus half their range.
  assign noise    = 18'(lfsr[NOISE_BITS-1:0]) - NOISE_OFS;
  assign raw_wide = 18'(BASELINE) + 18'(tri_q) + noise;
  assign raw      = sat16(raw_wide);

  assign tri_up = 17'(tri_q) + 17'(TRI_STEP);

  always_comb begin
    dir_d = dir_q;
    tri_d = tri_q;
    unique case (dir_q)
      UP: begin
        if (tri_up >= 17'(TRI_PEAK)) begin
          tri_d = TRI_PEAK;
          dir_d = DOWN;
        end else begin
          tri_d = tri_up[15:0];
        end
      end
      DOWN: begin
        if (tri_q <= TRI_STEP) begin
          tri_d = '0;
          dir_d = UP;
        end else begin
          tri_d = tri_q - TRI_STEP;
        end
      end
      default: begin
        tri_d = '0;
        dir_d = UP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tri_q <= '0;
      dir_q <= UP;
    end else if (tick) begin
      tri_q <= tri_d;
      dir_q <= dir_d;
    end
  end

  // Running sum stays exact in 18 bits: four 16-bit taps at most.
  assign sum_new = sum_q - 18'(hist[AVG_TAPS-1]) + 18'(raw);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < AVG_TAPS; i++) begin
        hist[i] <= '0;
      end
      sum_q       <= '0;
      sensor_data <= '0;
    end else if (tick) begin
      hist[0] <= raw;
      for (int i = 1; i < AVG_TAPS; i++) begin
        hist[i] <= hist[i-1];
      end
      sum_q       <= sum_new;
      sensor_data <= sample_t'(sum_new >> AVG_SHIFT);
    end
  end

endmodule

// File: tb/tb_data_acquisition.sv
// Self-checking bench for data_acquisition: default, saturating
// and divide-by-one instances against hand values and a small model.
module tb_data_acquisition;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] out_a, out_b, out_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_acquisition u_a (
    .clk         (clk),
    .reset       (reset),
    .sensor_data (out_a)
  );

  data_acquisition #(
    .BASELINE (16'hFFC0),
    .TRI_PEAK (16'h0100)
  ) u_b (
    .clk         (clk),
    .reset       (reset),
    .sensor_data (out_b)
  );

  data_acquisition #(
    .SAMPLE_DIV (1)
  ) u_c (
    .clk         (clk),
    .reset       (reset),
    .sensor_data (out_c)
  );

  typedef struct packed {
    logic [15:0]      lfsr;
    logic [15:0]      tv;
    logic             dn;
    logic [3:0][15:0] h;
    logic [15:0]      out;
  } m_t;

  m_t ma, mb, mc;
  int ca;

  function automatic m_t m_init();
    m_t s;
    s = '0;
    s.lfsr = 16'hACE1;
    return s;
  endfunction

  function automatic m_t m_step(m_t s, logic [15:0] base,
                                logic [15:0] peak);
    m_t o;
    int n, r, t, total;
    o = s;
    n = int'(s.lfsr[5:0]) - 32;
    r = int'(base) + int'(s.tv) + n;
    if (r < 0) r = 0;
    if (r > 65535) r = 65535;
    o.h = {s.h[2:0], r[15:0]};
    total = int'(o.h[0]) + int'(o.h[1]) + int'(o.h[2]) + int'(o.h[3]);
    o.out = 16'(total / 4);
    o.lfsr = s.lfsr[0] ? ((s.lfsr >> 1) ^ 16'hB400) : (s.lfsr >> 1);
    if (!s.dn) begin
      t = int'(s.tv) + 64;
      if (t >= int'(peak)) begin
        o.tv = peak;
        o.dn = 1'b1;
      end else begin
        o.tv = 16'(t);
      end
    end else if (s.tv <= 16'd64) begin
      o.tv = '0;
      o.dn = 1'b0;
    end else begin
      o.tv = s.tv - 16'd64;
    end
    return o;
  endfunction

  function automatic logic [15:0] first_seq(int k);
    logic [15:0] v;
    if (k < 4) v = 16'h0000;
    else if (k < 8) v = 16'h1000;
    else if (k < 12) v = 16'h2014;
    else if (k < 16) v = 16'h303A;
    else v = 16'h4069;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (!reset) begin
      ma = m_init();
      mb = m_init();
      mc = m_init();
      ca = 0;
    end else begin
      if (ca == 3) begin
        ma = m_step(ma, 16'h4000, 16'h1000);
        mb = m_step(mb, 16'hFFC0, 16'h0100);
        ca = 0;
      end else begin
        ca++;
      end
      mc = m_step(mc, 16'h4000, 16'h1000);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    checks += 3;
    if (out_a !== 16'h0000) begin
      failures++;
      $display("FAIL reset_a got=%h exp=0000", out_a);
    end
    if (out_b !== 16'h0000) begin
      failures++;
      $display("FAIL reset_b got=%h exp=0000", out_b);
    end
    if (out_c !== 16'h0000) begin
      failures++;
      $display("FAIL reset_c got=%h exp=0000", out_c);
    end
    reset = 1'b1;
  endtask

  task automatic test_first_ticks(string tag);
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if (out_a !== first_seq(k)) begin
        failures++;
        $display("FAIL %s clk%0d got=%h exp=%h",
                 tag, k, out_a, first_seq(k));
      end
    end
    checks++;
    if (out_a < 16'h3FE0 || out_a > 16'h4120) begin
      failures++;
      $display("FAIL %s range got=%h exp=3FE0..4120", tag, out_a);
    end
  endtask

  task automatic test_triangle();
    logic [15:0] o20;
    o20 = '0;
    for (int t = 1; t <= 70; t++) begin
      repeat (4) step();
      checks++;
      if (out_a !== ma.out) begin
        failures++;
        $display("FAIL tri tick%0d got=%h exp=%h", t, out_a, ma.out);
      end
      if (t == 20) o20 = out_a;
      if (t == 60) begin
        checks++;
        if (out_a <= o20 + 16'd400) begin
          failures++;
          $display("FAIL tri_rise got=%h exp>%h", out_a, o20 + 16'd400);
        end
      end
    end
    checks++;
    if (ma.dn !== 1'b1 || ma.tv >= 16'h1000) begin
      failures++;
      $display("FAIL tri_model_down got=%h exp<1000", ma.tv);
    end
  endtask

  task automatic test_reset_mid();
    repeat (10) step();
    reset = 1'b0;
    step();
    checks++;
    if (out_a !== 16'h0000) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=0000", out_a);
    end
    reset = 1'b1;
    test_first_ticks("rerun");
  endtask

  task automatic test_saturation();
    logic seen;
    seen = 1'b0;
    test_reset();
    for (int t = 1; t <= 40; t++) begin
      repeat (4) step();
      checks++;
      if (out_b !== mb.out) begin
        failures++;
        $display("FAIL sat tick%0d got=%h exp=%h", t, out_b, mb.out);
      end
      if (t > 8) begin
        checks++;
        if (out_b < 16'hF000) begin
          failures++;
          $display("FAIL sat_wrap tick%0d got=%h exp>=F000", t, out_b);
        end
      end
      if (out_b === 16'hFFFF) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL sat_ffff got=%b exp=1", seen);
    end
  endtask

  task automatic test_div1();
    test_reset();
    step();
    checks++;
    if (out_c !== 16'h1000) begin
      failures++;
      $display("FAIL div1_first got=%h exp=1000", out_c);
    end
    step();
    checks++;
    if (out_c !== 16'h2014) begin
      failures++;
      $display("FAIL div1_second got=%h exp=2014", out_c);
    end
    for (int k = 0; k < 30; k++) begin
      step();
      checks++;
      if (out_c !== mc.out) begin
        failures++;
        $display("FAIL div1 clk%0d got=%h exp=%h", k, out_c, mc.out);
      end
    end
  endtask

  initial begin
    ma = m_init();
    mb = m_init();
    mc = m_init();
    ca = 0;
    test_reset();
    test_first_ticks("first");
    test_triangle();
    test_reset_mid();
    test_saturation();
    test_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
